// File: rtl/i2s_tdm_tx_if.sv
// rtl/i2s_tdm_tx_if.sv - sample stream, format select and DAC pin bundle for i2s_tdm_tx
interface i2s_tdm_tx_if #(
   parameter int CHANNELS     = 2,
   parameter int SAMPLE_WIDTH = 16
);
   logic                             fmt;
   logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_data;
   logic                             sample_valid;
   logic                             sample_ready;
   logic                             underrun;
   logic                             i2s_sclk;
   logic                             i2s_ws;
   logic                             i2s_sd;

   modport master (
      output fmt, sample_data, sample_valid,
      input  sample_ready, underrun, i2s_sclk, i2s_ws, i2s_sd
   );

   modport slave (
      input  fmt, sample_data, sample_valid,
      output sample_ready, underrun, i2s_sclk, i2s_ws, i2s_sd
   );
endinterface

// File: rtl/i2s_tdm_tx.sv
// rtl/i2s_tdm_tx.sv - I2S / left-justified / TDM serial audio transmitter with one-frame skid buffer
// Define I2S_UNDERRUN_MUTE_EN to play silence on underrun instead of replaying the last frame.
module i2s_tdm_tx #(
   parameter int CHANNELS      = 2,
   parameter int SAMPLE_WIDTH  = 16,
   parameter int SLOT_WIDTH    = 32,
   parameter int SCLK_HALF_DIV = 2
) (
   input logic         clk,
   input logic         reset,
   i2s_tdm_tx_if.slave bus
);
   localparam int FRAME_BITS = CHANNELS * SLOT_WIDTH;
   localparam int DATA_W     = CHANNELS * SAMPLE_WIDTH;
   localparam int DW         = (SCLK_HALF_DIV > 1) ? $clog2(SCLK_HALF_DIV) : 1;
   localparam int BW         = $clog2(FRAME_BITS);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_HALF_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] SLOT_LIM = BW'(SLOT_WIDTH);

   logic [DW-1:0]         div_cnt_q, div_cnt_d;
   logic                  sclk_q, sclk_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  pend_full_q, pend_full_d;
   logic [DATA_W-1:0]     pend_q, pend_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic                  fmt_q, fmt_d;
   logic                  dly_q, dly_d;
   logic                  ws_q, ws_d;
   logic                  sd_q, sd_d;
   logic                  underrun_q, underrun_d;
   logic                  tc, fall, boundary, accept, cur_bit;

   // Frame bit index = slot*SLOT_WIDTH + k, with k counting from the sample MSB.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_W-1:0] s);
      logic [FRAME_BITS-1:0] f;
      f = '0;
      for (int ch = 0; ch < CHANNELS; ch++)
         for (int k = 0; k < SAMPLE_WIDTH; k++)
            f[ch*SLOT_WIDTH + k] = s[ch*SAMPLE_WIDTH + SAMPLE_WIDTH - 1 - k];
      return f;
   endfunction

   always_comb begin
      tc        = (div_cnt_q == DIV_LAST);
      fall      = tc && sclk_q;
      boundary  = fall && (bit_cnt_q == BIT_LAST);
      accept    = bus.sample_valid && !pend_full_q;

      div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
      sclk_d    = sclk_q ^ tc;
      bit_cnt_d = bit_cnt_q;
      if (fall)
         bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;

      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      frame_d     = frame_q;
      fmt_d       = fmt_q;
      underrun_d  = 1'b0;
      if (boundary) begin
         if (pend_full_q) begin
            frame_d     = build_frame(pend_q);
            fmt_d       = bus.fmt;
            pend_full_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
`ifdef I2S_UNDERRUN_MUTE_EN
            frame_d    = '0;
`else
            frame_d    = frame_q;
`endif
         end
      end
      // A frame accepted on a boundary clk waits for the following boundary.
      if (accept) begin
         pend_d      = bus.sample_data;
         pend_full_d = 1'b1;
      end

      cur_bit = frame_d[bit_cnt_d];
      dly_d   = dly_q;
      sd_d    = sd_q;
      ws_d    = ws_q;
      if (fall) begin
         dly_d = cur_bit;
         sd_d  = fmt_d ? cur_bit : dly_q;
         if (CHANNELS == 2)
            ws_d = (bit_cnt_d >= SLOT_LIM) ^ fmt_d;
         else
            ws_d = (bit_cnt_d == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q   <= '0;
         sclk_q      <= 1'b0;
         bit_cnt_q   <= BIT_LAST;
         pend_full_q <= 1'b0;
         pend_q      <= '0;
         frame_q     <= '0;
         fmt_q       <= 1'b0;
         dly_q       <= 1'b0;
         ws_q        <= 1'b0;
         sd_q        <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         sclk_q      <= sclk_d;
         bit_cnt_q   <= bit_cnt_d;
         pend_full_q <= pend_full_d;
         pend_q      <= pend_d;
         frame_q     <= frame_d;
         fmt_q       <= fmt_d;
         dly_q       <= dly_d;
         ws_q        <= ws_d;
         sd_q        <= sd_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.sample_ready = !pend_full_q;
   assign bus.underrun     = underrun_q;
   assign bus.i2s_sclk     = sclk_q;
   assign bus.i2s_ws       = ws_q;
   assign bus.i2s_sd       = sd_q;
endmodule

// File: doc/i2s_tdm_tx.md
# i2s_tdm_tx

- Parametrised serial audio transmitter; successor to the fixed stereo 16-bit I2S output stage.
- Serialises `CHANNELS` samples per frame, each `SAMPLE_WIDTH` bits wide and MSB-first, into `SLOT_WIDTH`-bit slots.
- Supports I2S and left-justified framing, selectable at runtime, plus TDM operation for more than two channels.
- Sits between the sample mixer and the external DAC pins: valid/ready input, one-frame skid buffer, underrun detection.

## Interface
- `CHANNELS`, default 2: channels per frame; even, 2..16. 2 = stereo WS; >2 = TDM frame-sync pulse.
- `SAMPLE_WIDTH`, default 16: bits per sample; ≤ `SLOT_WIDTH`.
- `SLOT_WIDTH`, default 32: sclk cycles per channel slot; unused LSBs are driven 0.
- `SCLK_HALF_DIV`, default 2: clk cycles per sclk half-period; ≥1.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `fmt` in 1: 0 = I2S (one-sclk data delay), 1 = left-justified. Sampled only at frame boundary.
- `sample_data` in `CHANNELS*SAMPLE_WIDTH`: channel n occupies bits [n*SAMPLE_WIDTH +: SAMPLE_WIDTH]. Channel 0 = left.
- `sample_valid` in 1: frame offered.
- `sample_ready` out 1: equals !pending_full. Reset value 1.
- `underrun` out 1: one-clk pulse when a frame boundary finds no pending frame. Reset value 0.
- `i2s_sclk` out 1: bit clock. Reset value 0.
- `i2s_ws` out 1: word select / frame sync. Reset value 0.
- `i2s_sd` out 1: serial data. Reset value 0.

## Operation
- FRAME_BITS = CHANNELS*SLOT_WIDTH.
- Frame rate = f_clk / (2*SCLK_HALF_DIV*FRAME_BITS).
- Divider counts 0..SCLK_HALF_DIV-1 and toggles `i2s_sclk` at terminal count.
- A fall event is the clk in which `i2s_sclk` goes 1→0. Fall events advance `bit_cnt` (0..FRAME_BITS-1, wraps).
- `bit_cnt` resets to FRAME_BITS-1, so the first fall event after reset is a frame boundary.
- Pending buffer holds one entry:
  - Accept occurs when sample_valid && sample_ready; the entry is stored and pending_full is set.
  - A boundary with pending_full set loads the shift frame from the buffer, clears pending_full and latches `fmt`.
- A sample accepted in the same clk as a boundary is held for the next boundary; that boundary is treated as an underrun.
- Underrun at a boundary: `underrun` pulses for 1 clk and the previous frame is replayed (see Configuration). The first boundary after reset underruns unless a frame was accepted earlier.
- Slot bit k of slot s = bit (SAMPLE_WIDTH-1-k) of channel s for k < SAMPLE_WIDTH, otherwise 0.
- LJ mode: `i2s_sd` carries frame bit `bit_cnt`.
- I2S mode: `i2s_sd` carries frame bit `bit_cnt`-1, taken from a one-bit delay register. At `bit_cnt`=0 it outputs the last bit of the previous frame.
- WS, CHANNELS==2:
  - I2S: `i2s_ws` = 0 in slot 0, 1 in slot 1.
  - LJ: inverted.
  - Derived from undelayed `bit_cnt`, so in I2S WS leads the data MSB by one sclk.
- WS, CHANNELS>2: `i2s_ws` = 1 only while `bit_cnt`==0, in both modes.

## Timing
- `i2s_sd` and `i2s_ws` are registered and update only on fall events. The DAC samples on sclk rising edges.
- Latency: a frame accepted before a boundary starts at that boundary. Its first MSB appears at that fall event (LJ) or one sclk later (I2S).
- `sample_ready` deasserts the clk after an accept and reasserts the clk after a load.
- Asserting `reset` mid-frame forces all outputs to reset values immediately. The pending entry and the replay frame are cleared to 0.

## Configuration
- `I2S_UNDERRUN_MUTE_EN` defined: an underrun boundary loads an all-zero frame, so the output is muted.
- Undefined (default): the shift frame is reloaded with the last successfully loaded frame, which repeats the previous sample.

## Test plan
- Stereo LJ, CH=2 SW=16 SLOT=16 DIV=1:
  - Stimulus: push data=32'hA5F0_1234.
  - Response: ws=1 over 16 bits 0x1234 MSB-first, then ws=0 over 0xA5F0. Period 64 clk per frame.
- Same config, fmt=0 (I2S): sd is the LJ pattern delayed by exactly one sclk and ws is the inverse. The first sd bit of the frame is the prior frame's LSB.
- Padding, SW=24 SLOT=32:
  - Stimulus: push 24'hFFFFFF on both channels.
  - Response: each slot is 24 ones followed by 8 zeros.
- Underrun:
  - Stimulus: push one frame, then hold valid=0.
  - Default build: `underrun` pulses once per boundary and the frame repeats.
  - With `I2S_UNDERRUN_MUTE_EN`: sd is all 0 after the first frame.
- TDM, CH=8 SLOT=32: ws is high for exactly 1 sclk every 256 sclk, at slot 0 bit 0. Channel 5 data appears at bits 160..191.
- Reset mid-frame at bit_cnt=10: sclk/ws/sd=0 and ready=1 during reset. After release, the first boundary pulses `underrun`.
